// File: rtl/crc16_serial_framer.sv
// crc16_serial_framer: accepts payload bytes, serialises them MSB first and
// appends the CRC-16 (poly 8005, init 0, MSB first, no reflection, no final XOR).
//
// Input handshake: a byte (data_i, last_i) is taken on a rising clk_i edge where
// valid_i && ready_o. ready_o depends only on registered state, never on valid_i.
// The producer may hold valid_i across stalls and may change data_i freely while
// ready_o is low.
module crc16_serial_framer (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [7:0]  data_i,
    input  logic        valid_i,
    input  logic        last_i,
    output logic        ready_o,
    output logic        ser_data_o,
    output logic        ser_valid_o,
    output logic        ser_crc_o,
    output logic [15:0] crc_o,
    output logic        done_o,
    output logic [1:0]  state_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        WAIT = 2'd2,
        CRC  = 2'd3
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [7:0]  byte_q;
    logic        last_q;
    logic [2:0]  bit_cnt;
    logic [3:0]  crc_cnt;
    logic [15:0] crc_q;
    logic        accept;

    // One step of the MSB-first serial CRC-16.
    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
        logic [15:0] shifted;
        shifted = {c[14:0], 1'b0};
        return (c[15] ^ b) ? (shifted ^ 16'h8005) : shifted;
    endfunction

    // ready_o: open in IDLE/WAIT, and on the last data bit of a non-final byte.
    always_comb begin
        ready_o = 1'b0;
        unique case (state_q)
            IDLE:    ready_o = 1'b1;
            WAIT:    ready_o = 1'b1;
            DATA:    ready_o = (bit_cnt == 3'd7) && !last_q;
            CRC:     ready_o = 1'b0;
            default: ready_o = 1'b0;
        endcase
    end

    assign accept  = valid_i && ready_o;
    assign state_o = state_q;

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Next-state decode and serial outputs.
    always_comb begin
        state_d     = state_q;
        ser_data_o  = 1'b0;
        ser_valid_o = 1'b0;
        ser_crc_o   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) state_d = DATA;
            end
            DATA: begin
                ser_valid_o = 1'b1;
                ser_data_o  = byte_q[7];
                if (bit_cnt == 3'd7) begin
                    if (last_q)      state_d = CRC;
                    else if (accept) state_d = DATA;
                    else             state_d = WAIT;
                end
            end
            WAIT: begin
                if (accept) state_d = DATA;
            end
            CRC: begin
                ser_valid_o = 1'b1;
                ser_crc_o   = 1'b1;
                ser_data_o  = crc_q[4'd15 - crc_cnt];
                if (crc_cnt == 4'd15) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath: byte latch/shift, bit counters, running CRC, result and done pulse.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            byte_q  <= 8'h00;
            last_q  <= 1'b0;
            bit_cnt <= 3'd0;
            crc_cnt <= 4'd0;
            crc_q   <= 16'h0000;
            crc_o   <= 16'h0000;
            done_o  <= 1'b0;
        end else begin
            done_o <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        byte_q  <= data_i;
                        last_q  <= last_i;
                        bit_cnt <= 3'd0;
                        crc_q   <= 16'h0000;
                    end
                end
                DATA: begin
                    crc_q   <= crc_step(crc_q, byte_q[7]);
                    byte_q  <= {byte_q[6:0], 1'b0};
                    // Wraps 7 -> 0, so the next byte (or WAIT/CRC) starts from zero.
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        crc_cnt <= 4'd0;
                        if (accept) begin
                            byte_q <= data_i;
                            last_q <= last_i;
                        end
                    end
                end
                WAIT: begin
                    if (accept) begin
                        byte_q  <= data_i;
                        last_q  <= last_i;
                        bit_cnt <= 3'd0;
                    end
                end
                CRC: begin
                    crc_cnt <= crc_cnt + 4'd1;
                    if (crc_cnt == 4'd15) begin
                        crc_o  <= crc_q;
                        done_o <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_crc16_serial_framer.sv
// Directed and randomised bench for crc16_serial_framer.
module tb_crc16_serial_framer;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [7:0]  data_i;
    logic        valid_i;
    logic        last_i;
    logic        ready_o;
    logic        ser_data_o;
    logic        ser_valid_o;
    logic        ser_crc_o;
    logic [15:0] crc_o;
    logic        done_o;
    logic [1:0]  state_o;

    int checks   = 0;
    int failures = 0;

    logic [15:0] exp_q[$];

    // Monitor state (per frame, snapshotted on done_o).
    int          done_cnt  = 0;
    logic [63:0] bits_sh   = '0;
    int          nbits     = 0;
    int          ncrc      = 0;
    int          gap       = 0;
    logic [15:0] res       = '0;
    logic        in_frame  = 1'b0;
    logic        order_err = 1'b0;
    logic        prev_done = 1'b0;
    logic [63:0] last_sh   = '0;
    int          last_nbits = 0;
    int          last_gap   = 0;

    crc16_serial_framer dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .data_i      (data_i),
        .valid_i     (valid_i),
        .last_i      (last_i),
        .ready_o     (ready_o),
        .ser_data_o  (ser_data_o),
        .ser_valid_o (ser_valid_o),
        .ser_crc_o   (ser_crc_o),
        .crc_o       (crc_o),
        .done_o      (done_o),
        .state_o     (state_o)
    );

    // Clock.
    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference serial CRC-16 step.
    function automatic logic [15:0] ref_bit(input logic [15:0] c, input logic b);
        logic [15:0] s;
        s = {c[14:0], 1'b0};
        return (c[15] ^ b) ? (s ^ 16'h8005) : s;
    endfunction

    function automatic logic [15:0] ref_byte(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c;
        for (int i = 7; i >= 0; i--) r = ref_bit(r, d[i]);
        return r;
    endfunction

    task automatic clear_frame();
        bits_sh   = '0;
        nbits     = 0;
        ncrc      = 0;
        gap       = 0;
        res       = '0;
        in_frame  = 1'b0;
        order_err = 1'b0;
    endtask

    // Scoreboard/monitor: collects serial bits, checks each completed frame.
    always @(negedge clk_i) begin
        if (!rst_ni) begin
            clear_frame();
            prev_done = 1'b0;
        end else begin
            if (done_o) begin
                check_eq("done_single_cycle", prev_done, 1'b0);
                check_eq("ready_in_done", ready_o, 1'b1);
                if (exp_q.size() == 0) check_eq("unexpected_done", 1, 0);
                else                   check_eq("crc_o", crc_o, exp_q.pop_front());
                check_eq("residue", res, 16'h0000);
                check_eq("crc_bit_count", ncrc, 16);
                check_eq("crc_bits_trailing", order_err, 1'b0);
                last_sh    = bits_sh;
                last_nbits = nbits;
                last_gap   = gap;
                done_cnt++;
                clear_frame();
            end else if (ser_valid_o) begin
                if (!ser_crc_o && ncrc > 0) order_err = 1'b1;
                bits_sh = {bits_sh[62:0], ser_data_o};
                nbits++;
                if (ser_crc_o) ncrc++;
                res      = ref_bit(res, ser_data_o);
                in_frame = 1'b1;
            end else if (in_frame) begin
                gap++;
            end
            prev_done = done_o;
        end
    end

    // Driver: offer one byte from posedge+1, return at posedge+1 after acceptance.
    task automatic send_byte(input logic [7:0] d, input logic l);
        int t;
        t = 0;
        valid_i = 1'b1;
        data_i  = d;
        last_i  = l;
        @(negedge clk_i);
        while (!ready_o && t < 200) begin
            @(negedge clk_i);
            t++;
        end
        if (!ready_o) check_eq("accept_timeout", 0, 1);
        @(posedge clk_i);
        #1;
        valid_i = 1'b0;
        data_i  = 8'($urandom_range(0, 255));
        last_i  = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_done();
        int start;
        int t;
        start = done_cnt;
        t = 0;
        while (done_cnt == start && t < 300) begin
            @(posedge clk_i);
            t++;
        end
        if (done_cnt == start) check_eq("done_timeout", 0, 1);
        #1;
    endtask

    // Watchdog.
    initial begin
        #1_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Stimulus.
    initial begin
        int t;
        int d;
        int n;
        int g;
        logic [15:0] c;
        logic [7:0]  fb[8];

        rst_ni  = 1'b0;
        valid_i = 1'b0;
        data_i  = 8'h00;
        last_i  = 1'b0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check_eq("rst_ready", ready_o, 1'b1);
        check_eq("rst_ser_valid", ser_valid_o, 1'b0);
        check_eq("rst_ser_crc", ser_crc_o, 1'b0);
        check_eq("rst_ser_data", ser_data_o, 1'b0);
        check_eq("rst_done", done_o, 1'b0);
        check_eq("rst_crc_o", crc_o, 16'h0000);
        check_eq("rst_state", state_o, 2'd0);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;

        // Single byte 0x01.
        exp_q.push_back(16'h8005);
        send_byte(8'h01, 1'b1);
        wait_done();
        check_eq("b01_nbits", last_nbits, 24);
        check_eq("b01_stream", last_sh[23:0], 24'h018005);
        check_eq("b01_gap", last_gap, 0);

        // Single byte 0x00.
        exp_q.push_back(16'h0000);
        send_byte(8'h00, 1'b1);
        wait_done();
        check_eq("b00_nbits", last_nbits, 24);
        check_eq("b00_stream", last_sh[23:0], 24'h000000);

        // Back-to-back 0x01, 0x00.
        exp_q.push_back(16'h8603);
        send_byte(8'h01, 1'b0);
        send_byte(8'h00, 1'b1);
        wait_done();
        check_eq("b2b_nbits", last_nbits, 32);
        check_eq("b2b_stream", last_sh[31:0], 32'h01008603);
        check_eq("b2b_gap", last_gap, 0);
        repeat (10) @(posedge clk_i);
        #1;
        check_eq("crc_o_hold", crc_o, 16'h8603);

        // 0x01, five WAIT cycles, then 0x00.
        exp_q.push_back(16'h8603);
        send_byte(8'h01, 1'b0);
        repeat (12) @(posedge clk_i);
        #1;
        check_eq("wait_state", state_o, 2'd2);
        check_eq("wait_ser_valid", ser_valid_o, 1'b0);
        send_byte(8'h00, 1'b1);
        wait_done();
        check_eq("wait_gap", last_gap, 5);
        check_eq("wait_nbits", last_nbits, 32);
        check_eq("wait_stream", last_sh[31:0], 32'h01008603);

        // Reset during the CRC phase.
        send_byte(8'h01, 1'b1);
        t = 0;
        do begin
            @(negedge clk_i);
            t++;
        end while (!ser_crc_o && t < 100);
        check_eq("reach_crc_phase", ser_crc_o, 1'b1);
        repeat (3) @(negedge clk_i);
        #2;
        d = done_cnt;
        rst_ni = 1'b0;
        #1;
        check_eq("mid_rst_ready", ready_o, 1'b1);
        check_eq("mid_rst_ser_valid", ser_valid_o, 1'b0);
        check_eq("mid_rst_ser_crc", ser_crc_o, 1'b0);
        check_eq("mid_rst_ser_data", ser_data_o, 1'b0);
        check_eq("mid_rst_done", done_o, 1'b0);
        check_eq("mid_rst_crc_o", crc_o, 16'h0000);
        check_eq("mid_rst_state", state_o, 2'd0);
        repeat (2) @(negedge clk_i);
        #2;
        rst_ni = 1'b1;
        repeat (30) @(posedge clk_i);
        #1;
        check_eq("no_done_after_rst", done_cnt, d);
        check_eq("crc_o_after_rst", crc_o, 16'h0000);
        exp_q.push_back(16'h8005);
        send_byte(8'h01, 1'b1);
        wait_done();
        check_eq("post_rst_stream", last_sh[23:0], 24'h018005);

        // Random frames against the reference model.
        for (int f = 0; f < 50; f++) begin
            n = $urandom_range(1, 8);
            c = 16'h0000;
            for (int i = 0; i < n; i++) begin
                fb[i] = 8'($urandom_range(0, 255));
                c = ref_byte(c, fb[i]);
            end
            exp_q.push_back(c);
            for (int i = 0; i < n; i++) begin
                g = $urandom_range(0, 3);
                if (g > 0) begin
                    repeat (g) @(posedge clk_i);
                    #1;
                end
                send_byte(fb[i], (i == n - 1));
            end
            wait_done();
            check_eq("rnd_nbits", last_nbits, 8 * n + 16);
        end

        repeat (5) @(posedge clk_i);
        check_eq("exp_q_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
